// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter in front of a single 32x8 memory.
// Port 0 (CPU) and port 1 (host/debug loader) share the bus round-robin.
// Port 0 may hold the bus with lock_0, but only for LOCK_MAX consecutive
// grants while port 1 is waiting. Each access runs IDLE -> SETUP -> STROBE
// (ACC_CYCLES cycles) -> DONE, and every output is registered.
module mem_bus_arbiter #(
    parameter int unsigned AW         = 5,
    parameter int unsigned DW         = 8,
    parameter int unsigned ACC_CYCLES = 2,
    parameter int unsigned LOCK_MAX   = 4
) (
    input  logic          clock,
    input  logic          rst,
    input  logic          req_0,
    input  logic          we_0,
    input  logic [AW-1:0] addr_0,
    input  logic [DW-1:0] wdata_0,
    input  logic          lock_0,
    output logic          gnt_0,
    output logic          done_0,
    output logic [DW-1:0] rdata_0,
    input  logic          req_1,
    input  logic          we_1,
    input  logic [AW-1:0] addr_1,
    input  logic [DW-1:0] wdata_1,
    output logic          gnt_1,
    output logic          done_1,
    output logic [DW-1:0] rdata_1,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_rd,
    output logic          mem_wr,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam logic [3:0] AccCycles = 4'(ACC_CYCLES);
    localparam logic [3:0] LockMax   = 4'(LOCK_MAX);

    typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StDone} state_e;

    state_e        r_state, w_state_d;
    logic          r_owner, w_owner_d;
    logic          r_last_owner, w_last_owner_d;
    logic [3:0]    r_cnt, w_cnt_d;
    logic [3:0]    r_lock_cnt, w_lock_cnt_d;

    logic          w_lock_ok, w_sel_valid, w_sel_port, w_last_strobe;
    logic          w_we_nx, w_drive_bus;
    logic [AW-1:0] w_addr_nx;
    logic [DW-1:0] w_wdata_nx;

    logic          r_gnt_0, r_gnt_1, r_done_0, r_done_1, r_mem_rd, r_mem_wr, r_busy;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata, r_rdata_0, r_rdata_1;
    logic          w_gnt_0_d, w_gnt_1_d, w_done_0_d, w_done_1_d, w_mem_rd_d, w_mem_wr_d;
    logic          w_busy_d;
    logic [AW-1:0] w_mem_addr_d;
    logic [DW-1:0] w_mem_wdata_d, w_rdata_0_d, w_rdata_1_d;

    // Arbitration decision and lock-counter bookkeeping (only meaningful in IDLE)
    always_comb begin
        w_lock_ok   = !r_last_owner && lock_0 && req_0 && (r_lock_cnt < LockMax);
        w_sel_valid = req_0 || req_1;
        if (w_lock_ok) begin
            w_sel_port = 1'b0;
        end else if (req_0 && req_1) begin
            w_sel_port = ~r_last_owner;
        end else begin
            w_sel_port = req_1;
        end

        w_lock_cnt_d = r_lock_cnt;
        if (r_state == StIdle) begin
            if (!req_1 || w_sel_port) begin
                w_lock_cnt_d = 4'd0;
            end else if (w_lock_ok) begin
                // Port 0 kept the bus while port 1 was waiting
                w_lock_cnt_d = r_lock_cnt + 4'd1;
            end
        end
    end

    // State register and per-access bookkeeping
    always_ff @(posedge clock) begin
        if (rst) begin
            r_state      <= StIdle;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_cnt        <= 4'd0;
            r_lock_cnt   <= 4'd0;
        end else begin
            r_state      <= w_state_d;
            r_owner      <= w_owner_d;
            r_last_owner <= w_last_owner_d;
            r_cnt        <= w_cnt_d;
            r_lock_cnt   <= w_lock_cnt_d;
        end
    end

    // Next-state logic for the access sequencer
    always_comb begin
        w_state_d      = r_state;
        w_owner_d      = r_owner;
        w_last_owner_d = r_last_owner;
        w_cnt_d        = r_cnt;
        w_last_strobe  = (r_cnt <= 4'd1);
        unique case (r_state)
            StIdle: begin
                if (w_sel_valid) begin
                    w_state_d = StSetup;
                    w_owner_d = w_sel_port;
                end
            end
            StSetup: begin
                w_state_d = StStrobe;
                w_cnt_d   = AccCycles;
            end
            StStrobe: begin
                if (w_last_strobe) begin
                    w_state_d = StDone;
                end else begin
                    w_cnt_d = r_cnt - 4'd1;
                end
            end
            StDone: begin
                w_state_d      = StIdle;
                w_last_owner_d = r_owner;
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs, derived from the next state
    always_comb begin
        w_we_nx    = w_owner_d ? we_1 : we_0;
        w_addr_nx  = w_owner_d ? addr_1 : addr_0;
        w_wdata_nx = w_owner_d ? wdata_1 : wdata_0;

        w_busy_d   = (w_state_d != StIdle);
        w_gnt_0_d  = w_busy_d && !w_owner_d;
        w_gnt_1_d  = w_busy_d && w_owner_d;
        w_mem_rd_d = (w_state_d == StStrobe) && !w_we_nx;
        w_mem_wr_d = (w_state_d == StStrobe) && w_we_nx;
        w_done_0_d = (w_state_d == StDone) && !w_owner_d;
        w_done_1_d = (w_state_d == StDone) && w_owner_d;

        // Follow the owner's address/data from grant until the last strobe; hold otherwise
        w_drive_bus   = ((r_state == StIdle) && w_sel_valid) || (r_state == StSetup) ||
                        (r_state == StStrobe);
        w_mem_addr_d  = r_mem_addr;
        w_mem_wdata_d = r_mem_wdata;
        if (w_drive_bus) begin
            w_mem_addr_d = w_addr_nx;
            if (w_we_nx) begin
                w_mem_wdata_d = w_wdata_nx;
            end
        end

        w_rdata_0_d = r_rdata_0;
        w_rdata_1_d = r_rdata_1;
        if ((r_state == StStrobe) && w_last_strobe && !w_we_nx) begin
            if (r_owner) begin
                w_rdata_1_d = mem_rdata;
            end else begin
                w_rdata_0_d = mem_rdata;
            end
        end
    end

    // Output registers, all cleared by reset
    always_ff @(posedge clock) begin
        if (rst) begin
            r_gnt_0     <= 1'b0;
            r_gnt_1     <= 1'b0;
            r_done_0    <= 1'b0;
            r_done_1    <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_busy      <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata_0   <= '0;
            r_rdata_1   <= '0;
        end else begin
            r_gnt_0     <= w_gnt_0_d;
            r_gnt_1     <= w_gnt_1_d;
            r_done_0    <= w_done_0_d;
            r_done_1    <= w_done_1_d;
            r_mem_rd    <= w_mem_rd_d;
            r_mem_wr    <= w_mem_wr_d;
            r_busy      <= w_busy_d;
            r_mem_addr  <= w_mem_addr_d;
            r_mem_wdata <= w_mem_wdata_d;
            r_rdata_0   <= w_rdata_0_d;
            r_rdata_1   <= w_rdata_1_d;
        end
    end

    assign gnt_0     = r_gnt_0;
    assign gnt_1     = r_gnt_1;
    assign done_0    = r_done_0;
    assign done_1    = r_done_1;
    assign rdata_0   = r_rdata_0;
    assign rdata_1   = r_rdata_1;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_rd    = r_mem_rd;
    assign mem_wr    = r_mem_wr;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: transaction-level reference model checked
// every cycle, directed scenarios with literal expectations, and a second
// instance built with ACC_CYCLES=1.
module tb_mem_bus_arbiter;

    localparam int ACC  = 2;
    localparam int LMAX = 4;

    logic       clock = 1'b0;
    logic       rst   = 1'b1;
    logic       req_0 = 1'b0, we_0 = 1'b0, lock_0 = 1'b0;
    logic [4:0] addr_0 = '0;
    logic [7:0] wdata_0 = '0;
    logic       req_1 = 1'b0, we_1 = 1'b0;
    logic [4:0] addr_1 = '0;
    logic [7:0] wdata_1 = '0;
    logic       gnt_0, gnt_1, done_0, done_1, mem_rd, mem_wr, busy;
    logic [7:0] rdata_0, rdata_1, mem_wdata, mem_rdata;
    logic [4:0] mem_addr;

    always #5 clock = ~clock;

    mem_bus_arbiter #(.AW(5), .DW(8), .ACC_CYCLES(ACC), .LOCK_MAX(LMAX)) u_dut (
        .clock(clock), .rst(rst),
        .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0), .lock_0(lock_0),
        .gnt_0(gnt_0), .done_0(done_0), .rdata_0(rdata_0),
        .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1),
        .gnt_1(gnt_1), .done_1(done_1), .rdata_1(rdata_1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    // Memory shared by both instances; loaded on the first clock edge
    logic [7:0] mem [32];
    bit         mem_init = 1'b0;
    always @(posedge clock) begin
        if (!mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= (i == 27) ? 8'h90 : 8'(i * 7 + 1);
            mem_init <= 1'b1;
        end else if (mem_wr) begin
            mem[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = mem_rd ? mem[mem_addr] : 8'h00;

    // Second instance with single-cycle strobes, only port 1 exercised
    logic       rst_b = 1'b1, req_1b = 1'b0;
    logic       b_gnt_0, b_done_0, b_gnt_1, done_1b, mem_rd_b, mem_wr_b, b_busy;
    logic [7:0] b_rdata_0, rdata_1b, b_mem_wdata, mem_rdata_b;
    logic [4:0] mem_addr_b;
    bit         b_finished = 1'b0;

    mem_bus_arbiter #(.AW(5), .DW(8), .ACC_CYCLES(1), .LOCK_MAX(LMAX)) u_dut_acc1 (
        .clock(clock), .rst(rst_b),
        .req_0(1'b0), .we_0(1'b0), .addr_0(5'd0), .wdata_0(8'd0), .lock_0(1'b0),
        .gnt_0(b_gnt_0), .done_0(b_done_0), .rdata_0(b_rdata_0),
        .req_1(req_1b), .we_1(1'b0), .addr_1(5'h1B), .wdata_1(8'd0),
        .gnt_1(b_gnt_1), .done_1(done_1b), .rdata_1(rdata_1b),
        .mem_addr(mem_addr_b), .mem_wdata(b_mem_wdata), .mem_rd(mem_rd_b), .mem_wr(mem_wr_b),
        .mem_rdata(mem_rdata_b), .busy(b_busy)
    );
    assign mem_rdata_b = mem_rd_b ? mem[mem_addr_b] : 8'h00;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- Reference model ----------------
    // m_ph counts cycles since the grant edge: 1 = setup, 2..ACC+1 = strobe,
    // ACC+2 = done, 0 = no access in progress.
    int         m_ph = 0;
    bit         m_owner, m_last, m_we, m_pick, m_locked, m_started = 0;
    logic [4:0] m_addr, e_mem_addr;
    logic [7:0] m_wdata, e_mem_wdata;
    int         m_lcnt;
    logic [7:0] m_rdata [2];
    logic [7:0] m_mem [32];

    always @(posedge clock) begin
        cyc++;
        if (!m_started) begin
            for (int i = 0; i < 32; i++) m_mem[i] = (i == 27) ? 8'h90 : 8'(i * 7 + 1);
        end
        m_started = 1;
        if (rst) begin
            m_ph = 0; m_last = 1; m_lcnt = 0;
            m_rdata[0] = 0; m_rdata[1] = 0;
            e_mem_addr = 0; e_mem_wdata = 0;
        end else if (m_ph == 0) begin
            m_locked = (m_last == 0) && lock_0 && req_0 && (m_lcnt < LMAX);
            if (req_0 || req_1) begin
                if (m_locked)            m_pick = 0;
                else if (req_0 && req_1) m_pick = !m_last;
                else                     m_pick = req_1;
                m_ph = 1; m_owner = m_pick;
                m_we    = m_pick ? we_1 : we_0;
                m_addr  = m_pick ? addr_1 : addr_0;
                m_wdata = m_pick ? wdata_1 : wdata_0;
                e_mem_addr = m_addr;
                if (m_we) e_mem_wdata = m_wdata;
            end
            if (!req_1 || ((req_0 || req_1) && m_pick)) m_lcnt = 0;
            else if (m_locked) m_lcnt++;
        end else if (m_ph == ACC + 2) begin
            m_last = m_owner;
            m_ph = 0;
        end else begin
            if (m_ph == ACC + 1) begin
                if (m_we) m_mem[m_addr] = m_wdata;
                else      m_rdata[m_owner] = m_mem[m_addr];
            end
            m_ph++;
        end
    end

    // Compare all outputs against the model every cycle
    always @(negedge clock) begin
        if (m_started) begin
            check("gnt_0",     gnt_0,     (m_ph > 0) && !m_owner);
            check("gnt_1",     gnt_1,     (m_ph > 0) && m_owner);
            check("busy",      busy,      m_ph > 0);
            check("mem_rd",    mem_rd,    (m_ph >= 2) && (m_ph <= ACC + 1) && !m_we);
            check("mem_wr",    mem_wr,    (m_ph >= 2) && (m_ph <= ACC + 1) && m_we);
            check("done_0",    done_0,    (m_ph == ACC + 2) && !m_owner);
            check("done_1",    done_1,    (m_ph == ACC + 2) && m_owner);
            check("mem_addr",  mem_addr,  e_mem_addr);
            check("mem_wdata", mem_wdata, e_mem_wdata);
            check("rdata_0",   rdata_0,   m_rdata[0]);
            check("rdata_1",   rdata_1,   m_rdata[1]);
        end
    end

    // ---------------- Requesters and completion log ----------------
    typedef struct packed {
        logic       we;
        logic [4:0] addr;
        logic [7:0] wdata;
    } acc_t;

    acc_t       q0[$], q1[$];
    int         raise_cyc [2];
    int         strobe_run = 0;
    int         log_port[$], log_off[$], log_strobe[$];
    logic [7:0] log_rdata[$];

    always @(negedge clock) begin : requester
        bit popped0, popped1;
        popped0 = 0;
        popped1 = 0;
        if (rst) strobe_run = 0;
        else if (mem_rd || mem_wr) strobe_run++;
        if (!rst && done_0 === 1'b1) begin
            log_port.push_back(0); log_off.push_back(cyc - raise_cyc[0]);
            log_strobe.push_back(strobe_run); log_rdata.push_back(rdata_0);
            strobe_run = 0; void'(q0.pop_front()); popped0 = 1;
        end
        if (!rst && done_1 === 1'b1) begin
            log_port.push_back(1); log_off.push_back(cyc - raise_cyc[1]);
            log_strobe.push_back(strobe_run); log_rdata.push_back(rdata_1);
            strobe_run = 0; void'(q1.pop_front()); popped1 = 1;
        end
        if (q0.size() > 0) begin
            if (!req_0) raise_cyc[0] = cyc;
            else if (popped0) raise_cyc[0] = cyc + 1;
            req_0 = 1; we_0 = q0[0].we; addr_0 = q0[0].addr; wdata_0 = q0[0].wdata;
        end else begin
            req_0 = 0;
        end
        if (q1.size() > 0) begin
            if (!req_1) raise_cyc[1] = cyc;
            else if (popped1) raise_cyc[1] = cyc + 1;
            req_1 = 1; we_1 = q1[0].we; addr_1 = q1[0].addr; wdata_1 = q1[0].wdata;
        end else begin
            req_1 = 0;
        end
    end

    task automatic push(input int port, input logic we, input logic [4:0] a, input logic [7:0] d);
        acc_t t;
        t.we = we; t.addr = a; t.wdata = d;
        if (port == 0) q0.push_back(t);
        else           q1.push_back(t);
    endtask

    task automatic clear_log();
        log_port.delete(); log_off.delete(); log_strobe.delete(); log_rdata.delete();
    endtask

    task automatic wait_quiet(input int budget, input string what);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clock); #3;
            if (q0.size() == 0 && q1.size() == 0 && busy === 1'b0) begin
                ok = 1;
                break;
            end
        end
        check({"timeout_", what}, ok, 1);
    endtask

    // ---------------- ACC_CYCLES=1 instance ----------------
    initial begin : acc1_test
        int t0, first, n_rd, d;
        first = -1; n_rd = 0; d = -1;
        repeat (2) @(negedge clock);
        rst_b = 0;
        @(negedge clock);
        req_1b = 1; t0 = cyc;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (mem_rd_b) begin
                n_rd++;
                if (first < 0) first = cyc - t0;
            end
            if (done_1b) begin
                d = cyc - t0; req_1b = 0;
                break;
            end
        end
        check("acc1_done_cycle", d, 3);
        check("acc1_strobe_len", n_rd, 1);
        check("acc1_strobe_first", first, 2);
        check("acc1_rdata", rdata_1b, 8'h90);
        b_finished = 1;
    end

    // ---------------- Directed scenarios ----------------
    int exp_seq [12];
    initial begin : stim
        exp_seq = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
        repeat (3) @(negedge clock);
        check("rst_gnt_0", gnt_0, 0);
        check("rst_busy", busy, 0);
        check("rst_rdata_1", rdata_1, 0);
        rst = 0;

        // Single read by port 1
        @(posedge clock); #2;
        clear_log(); push(1, 0, 5'h1B, 8'h00);
        wait_quiet(40, "single_read");
        check("t1_count", log_port.size(), 1);
        check("t1_port", log_port[0], 1);
        check("t1_done_cycle", log_off[0], 4);
        check("t1_strobe_len", log_strobe[0], 2);
        check("t1_rdata", log_rdata[0], 8'h90);

        // Port 0 write then read back
        @(posedge clock); #2;
        clear_log(); push(0, 1, 5'h05, 8'hA5); push(0, 0, 5'h05, 8'h00);
        wait_quiet(40, "write_read");
        check("t2_count", log_port.size(), 2);
        check("t2_wr_strobe_len", log_strobe[0], 2);
        check("t2_rdata_after_wr", log_rdata[0], 8'h00);
        check("t2_mem_written", mem[5], 8'hA5);
        check("t2_rdata_read", log_rdata[1], 8'hA5);

        // Contention straight after reset, then alternation
        @(posedge clock); #2; rst = 1;
        @(posedge clock); #2; rst = 0;
        clear_log();
        push(0, 0, 5'd1, 8'd0); push(1, 0, 5'd2, 8'd0);
        push(0, 0, 5'd3, 8'd0); push(1, 0, 5'd4, 8'd0);
        wait_quiet(80, "contention");
        check("t3_count", log_port.size(), 4);
        check("t3_first", log_port[0], 0);
        check("t3_second", log_port[1], 1);
        check("t3_third", log_port[2], 0);
        check("t3_fourth", log_port[3], 1);
        check("t3_done0_cycle", log_off[0], 4);
        check("t3_done1_cycle", log_off[1], 9);
        check("t3_rdata_p0", log_rdata[0], 8'h08);
        check("t3_rdata_p1", log_rdata[1], 8'h0F);

        // Lock bound: five port 0 grants, then port 1, twice
        @(posedge clock); #2;
        clear_log(); lock_0 = 1;
        for (int i = 0; i < 10; i++) push(0, 0, 5'(i), 8'd0);
        push(1, 0, 5'h1B, 8'd0); push(1, 0, 5'h1B, 8'd0);
        wait_quiet(200, "lock");
        lock_0 = 0;
        check("t4_count", log_port.size(), 12);
        for (int i = 0; i < 12; i++) check($sformatf("t4_grant%0d", i), log_port[i], exp_seq[i]);

        // Reset in the middle of a port 1 write, then reissue
        @(posedge clock); #2;
        clear_log(); push(1, 1, 5'h0A, 8'h5C);
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 20; i++) begin
                @(posedge clock); #3;
                if (mem_wr) begin seen = 1; break; end
            end
            check("t5_saw_strobe", seen, 1);
        end
        rst = 1;
        @(posedge clock); #1;
        check("t5_mem_wr", mem_wr, 0);
        check("t5_busy", busy, 0);
        check("t5_gnt_1", gnt_1, 0);
        check("t5_done_1", done_1, 0);
        check("t5_rdata_1", rdata_1, 0);
        #2 rst = 0;
        wait_quiet(40, "reissue");
        check("t5_count", log_port.size(), 1);
        check("t5_port", log_port[0], 1);
        check("t5_strobe_len", log_strobe[0], 2);
        @(posedge clock); #2;
        push(1, 0, 5'h0A, 8'h00);
        wait_quiet(40, "readback");
        check("t5_readback", log_rdata[1], 8'h5C);

        for (int i = 0; i < 100 && !b_finished; i++) @(posedge clock);
        check("acc1_finished", b_finished, 1);
        repeat (2) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
